// File: rtl/ps2_kbmatrix.sv
// ps2_kbmatrix: PS/2 scan-set-2 receiver and decoder producing the live 64-bit Z88 key matrix.
// Matrix bit index is row*8+col, active low (0 = key held).
module ps2_kbmatrix #(
    parameter int unsigned FILTER  = 8,     // must be >= 2
    parameter int unsigned TIMEOUT = 50000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [63:0] kbmatrix,
    output logic [7:0]  kbdcode,
    output logic        scan_valid,
    output logic        frame_err
);

    localparam int unsigned WdW = $clog2(TIMEOUT + 1);
    localparam logic [WdW-1:0] WdLast = WdW'(TIMEOUT - 1);

    typedef enum logic [2:0] {StIdle, StData, StParity, StStop, StDone} state_e;

    state_e            state_q, state_d;
    logic [1:0]        clk_sync_q, data_sync_q;
    logic [FILTER-1:0] filt_q;
    logic              clk_filt_q, clk_filt_d;
    logic              sample, ps2_din;
    logic [7:0]        shift_q;
    logic [2:0]        bit_cnt_q;
    logic              parity_ok_q;
    logic [WdW-1:0]    wd_q;
    logic              timeout;
    logic              cnt_clr, shift_en, par_en, stop_err, byte_done;
    logic              brk_q, ext_q;
    logic [2:0]        skip_q;
    logic              map_hit;
    logic [5:0]        map_bit;

    assign ps2_din = data_sync_q[1];

    // Synchronize both PS/2 lines and run the clock agreement filter.
    always_ff @(posedge clk) begin
        if (reset) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            filt_q      <= '1;
            clk_filt_q  <= 1'b1;
        end else begin
            clk_sync_q  <= {clk_sync_q[0], ps2_clk};
            data_sync_q <= {data_sync_q[0], ps2_data};
            filt_q      <= {filt_q[FILTER-2:0], clk_sync_q[1]};
            clk_filt_q  <= clk_filt_d;
        end
    end

    // Filtered clock only moves once every sample in the window agrees.
    always_comb begin
        clk_filt_d = clk_filt_q;
        if (&filt_q) begin
            clk_filt_d = 1'b1;
        end else if (~|filt_q) begin
            clk_filt_d = 1'b0;
        end
        sample  = clk_filt_q & ~clk_filt_d;
        timeout = (state_q != StIdle) && !sample && (wd_q == WdLast);
    end

    // Receiver state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Receiver next-state logic; a watchdog expiry abandons the frame from any state.
    always_comb begin
        state_d = state_q;
        if (timeout) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:   if (sample && !ps2_din) state_d = StData;
                StData:   if (sample && bit_cnt_q == 3'd7) state_d = StParity;
                StParity: if (sample) state_d = StStop;
                StStop:   if (sample) state_d = (ps2_din && parity_ok_q) ? StDone : StIdle;
                StDone:   state_d = StIdle;
                default:  state_d = StIdle;
            endcase
        end
    end

    // Receiver per-state strobes into the datapath and decoder.
    always_comb begin
        cnt_clr   = 1'b0;
        shift_en  = 1'b0;
        par_en    = 1'b0;
        stop_err  = 1'b0;
        byte_done = 1'b0;
        case (state_q)
            StIdle:   cnt_clr   = sample && !ps2_din;
            StData:   shift_en  = sample;
            StParity: par_en    = sample;
            StStop:   stop_err  = sample && !(ps2_din && parity_ok_q);
            StDone:   byte_done = 1'b1;
            default:  ;
        endcase
    end

    // Shift register, bit counter, parity check, watchdog and error pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            parity_ok_q <= 1'b0;
            wd_q        <= '0;
            frame_err   <= 1'b0;
        end else begin
            if (cnt_clr) begin
                bit_cnt_q <= '0;
            end else if (shift_en) begin
                shift_q   <= {ps2_din, shift_q[7:1]};
                bit_cnt_q <= bit_cnt_q + 3'd1;
            end
            if (par_en) begin
                parity_ok_q <= ^{shift_q, ps2_din};
            end
            wd_q      <= (state_q == StIdle || sample) ? '0 : wd_q + 1'b1;
            frame_err <= stop_err | timeout;
        end
    end

    // Scan code map keyed by {extended, code}; unlisted codes leave the matrix alone.
    always_comb begin
        map_hit = 1'b1;
        map_bit = 6'd0;
        case ({ext_q, shift_q})
            9'h01C: map_bit = 6'd45;  // A
            9'h05A: map_bit = 6'd6;   // Enter
            9'h029: map_bit = 6'd46;  // Space
            9'h012: map_bit = 6'd54;  // Left shift
            9'h059: map_bit = 6'd63;  // Right shift
            9'h175: map_bit = 6'd30;  // Up
            9'h16B: map_bit = 6'd28;  // Left
            9'h066: map_bit = 6'd7;   // Backspace -> DEL
            9'h174: map_bit = 6'd61;  // Right
            9'h172: map_bit = 6'd62;  // Down
            9'h016: map_bit = 6'd0;   // 1
            9'h01E: map_bit = 6'd1;   // 2
            9'h026: map_bit = 6'd2;   // 3
            9'h025: map_bit = 6'd3;   // 4
            9'h02E: map_bit = 6'd4;   // 5
            9'h036: map_bit = 6'd5;   // 6
            9'h03D: map_bit = 6'd8;   // 7
            9'h03E: map_bit = 6'd9;   // 8
            9'h046: map_bit = 6'd10;  // 9
            9'h045: map_bit = 6'd11;  // 0
            9'h015: map_bit = 6'd12;  // Q
            9'h01D: map_bit = 6'd13;  // W
            9'h024: map_bit = 6'd14;  // E
            9'h02D: map_bit = 6'd15;  // R
            9'h02C: map_bit = 6'd16;  // T
            9'h035: map_bit = 6'd17;  // Y
            9'h03C: map_bit = 6'd18;  // U
            9'h043: map_bit = 6'd19;  // I
            9'h044: map_bit = 6'd20;  // O
            9'h04D: map_bit = 6'd21;  // P
            9'h01B: map_bit = 6'd22;  // S
            9'h023: map_bit = 6'd23;  // D
            9'h02B: map_bit = 6'd24;  // F
            9'h034: map_bit = 6'd25;  // G
            9'h033: map_bit = 6'd26;  // H
            9'h03B: map_bit = 6'd27;  // J
            9'h042: map_bit = 6'd29;  // K
            9'h04B: map_bit = 6'd31;  // L
            9'h01A: map_bit = 6'd32;  // Z
            9'h022: map_bit = 6'd33;  // X
            9'h021: map_bit = 6'd34;  // C
            9'h02A: map_bit = 6'd35;  // V
            9'h032: map_bit = 6'd36;  // B
            9'h031: map_bit = 6'd37;  // N
            9'h03A: map_bit = 6'd38;  // M
            9'h041: map_bit = 6'd39;  // ,
            9'h049: map_bit = 6'd40;  // .
            9'h04A: map_bit = 6'd41;  // /
            9'h04C: map_bit = 6'd42;  // ;
            9'h052: map_bit = 6'd43;  // '
            9'h054: map_bit = 6'd44;  // [
            9'h05B: map_bit = 6'd47;  // ]
            9'h04E: map_bit = 6'd48;  // -
            9'h055: map_bit = 6'd49;  // =
            9'h05D: map_bit = 6'd50;  // backslash
            9'h00E: map_bit = 6'd51;  // backtick -> pound
            9'h076: map_bit = 6'd52;  // Esc
            9'h00D: map_bit = 6'd53;  // Tab
            9'h058: map_bit = 6'd55;  // Caps lock
            9'h011: map_bit = 6'd56;  // Left alt -> Diamond
            9'h014: map_bit = 6'd57;  // Left ctrl -> Square
            9'h005: map_bit = 6'd58;  // F1 -> Help
            9'h006: map_bit = 6'd59;  // F2 -> Index
            9'h004: map_bit = 6'd60;  // F3 -> Menu
            default: map_hit = 1'b0;
        endcase
    end

    // Byte decoder: prefix flags, Pause swallowing and matrix updates.
    always_ff @(posedge clk) begin
        if (reset) begin
            kbmatrix   <= '1;
            kbdcode    <= '0;
            scan_valid <= 1'b0;
            brk_q      <= 1'b0;
            ext_q      <= 1'b0;
            skip_q     <= '0;
        end else begin
            scan_valid <= byte_done;
            if (byte_done) begin
                kbdcode <= shift_q;
                if (skip_q != 3'd0) begin
                    skip_q <= skip_q - 3'd1;
                end else begin
                    case (shift_q)
                        8'hE1: skip_q <= 3'd7;
                        8'hE0: ext_q  <= 1'b1;
                        8'hF0: brk_q  <= 1'b1;
                        8'hAA: begin
                            kbmatrix <= '1;
                            brk_q    <= 1'b0;
                            ext_q    <= 1'b0;
                        end
                        8'h00, 8'hFA, 8'hFE, 8'hFF: begin
                            brk_q <= 1'b0;
                            ext_q <= 1'b0;
                        end
                        default: begin
                            if (map_hit) begin
                                kbmatrix[map_bit] <= brk_q;
                            end
                            brk_q <= 1'b0;
                            ext_q <= 1'b0;
                        end
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_kbmatrix.sv
// Directed bench for ps2_kbmatrix: drives PS/2 frames and checks matrix, code and pulses.
module tb_ps2_kbmatrix;

    localparam int unsigned FILTER  = 8;
    localparam int unsigned TIMEOUT = 100;
    localparam int          HP      = 40;   // PS/2 half period in clk cycles

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        ps2_clk = 1'b1;
    logic        ps2_data = 1'b1;
    logic [63:0] kbmatrix;
    logic [7:0]  kbdcode;
    logic        scan_valid;
    logic        frame_err;

    int total = 0;
    int bad = 0;
    int sv_cnt = 0;
    int fe_cnt = 0;
    int cyc = 0;
    int fe_cyc = 0;
    int last_fall = 0;
    logic [63:0] exp_mat;

    ps2_kbmatrix #(
        .FILTER (FILTER),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .kbmatrix  (kbmatrix),
        .kbdcode   (kbdcode),
        .scan_valid(scan_valid),
        .frame_err (frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count high cycles of the strobes; a one-cycle pulse adds exactly one.
    always @(negedge clk) begin
        if (scan_valid === 1'b1) sv_cnt = sv_cnt + 1;
        if (frame_err === 1'b1) begin
            fe_cnt = fe_cnt + 1;
            fe_cyc = cyc;
        end
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b);
        ps2_data = b;
        wait_cycles(HP / 2);
        ps2_clk = 1'b0;
        last_fall = cyc;
        wait_cycles(HP);
        ps2_clk = 1'b1;
        wait_cycles(HP / 2);
    endtask

    task automatic send_raw(input logic [7:0] d, input logic par, input logic stp);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(par);
        send_bit(stp);
        ps2_data = 1'b1;
        wait_cycles(HP);
    endtask

    task automatic send_byte(input logic [7:0] d);
        send_raw(d, ~^d, 1'b1);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        wait_cycles(5);
        reset = 1'b0;
        wait_cycles(2);
        total++;
        if (kbmatrix !== 64'hFFFF_FFFF_FFFF_FFFF) begin
            bad++; $display("FAIL reset_matrix: got %h want all ones", kbmatrix);
        end
        total++;
        if (kbdcode !== 8'h00) begin
            bad++; $display("FAIL reset_kbdcode: got %h want 00", kbdcode);
        end
        total++;
        if (scan_valid !== 1'b0) begin
            bad++; $display("FAIL reset_scan_valid: got %b want 0", scan_valid);
        end
        total++;
        if (frame_err !== 1'b0) begin
            bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err);
        end
    endtask

    task automatic test_make_break;
        int sv0, fe0;
        exp_mat = '1;
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        send_byte(8'h1C);
        exp_mat[45] = 1'b0;
        total++;
        if (sv_cnt - sv0 !== 1) begin
            bad++; $display("FAIL make_scan_valid: got %0d pulses want 1", sv_cnt - sv0);
        end
        total++;
        if (kbdcode !== 8'h1C) begin
            bad++; $display("FAIL make_kbdcode: got %h want 1c", kbdcode);
        end
        total++;
        if (kbmatrix !== exp_mat) begin
            bad++; $display("FAIL make_a_matrix: got %h want %h", kbmatrix, exp_mat);
        end
        send_byte(8'hF0);
        total++;
        if (kbdcode !== 8'hF0 || kbmatrix !== exp_mat) begin
            bad++; $display("FAIL f0_prefix: got %h/%h want f0/%h", kbdcode, kbmatrix, exp_mat);
        end
        send_byte(8'h1C);
        exp_mat[45] = 1'b1;
        total++;
        if (kbmatrix !== exp_mat) begin
            bad++; $display("FAIL break_a_matrix: got %h want %h", kbmatrix, exp_mat);
        end
        total++;
        if (fe_cnt !== fe0 || sv_cnt - sv0 !== 3) begin
            bad++; $display("FAIL make_break_pulses: got fe=%0d sv=%0d want fe=0 sv=3",
                            fe_cnt - fe0, sv_cnt - sv0);
        end
    endtask

    task automatic test_extended;
        send_byte(8'hE0);
        send_byte(8'h75);
        exp_mat[30] = 1'b0;
        total++;
        if (kbmatrix !== exp_mat) begin
            bad++; $display("FAIL up_make: got %h want %h", kbmatrix, exp_mat);
        end
        send_byte(8'h75);
        total++;
        if (kbmatrix !== exp_mat) begin
            bad++; $display("FAIL plain_75_make: got %h want %h", kbmatrix, exp_mat);
        end
        send_byte(8'hF0);
        send_byte(8'h75);
        total++;
        if (kbmatrix !== exp_mat) begin
            bad++; $display("FAIL plain_75_break: got %h want %h", kbmatrix, exp_mat);
        end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        exp_mat[30] = 1'b1;
        total++;
        if (kbmatrix !== exp_mat) begin
            bad++; $display("FAIL up_break: got %h want %h", kbmatrix, exp_mat);
        end
    endtask

    task automatic test_frame_errors;
        int sv0, fe0;
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        send_raw(8'h5A, ^8'h5A, 1'b1);   // wrong parity
        total++;
        if (fe_cnt - fe0 !== 1 || sv_cnt !== sv0) begin
            bad++; $display("FAIL parity_err: got fe=%0d sv=%0d want fe=1 sv=0",
                            fe_cnt - fe0, sv_cnt - sv0);
        end
        total++;
        if (kbmatrix !== exp_mat) begin
            bad++; $display("FAIL parity_err_matrix: got %h want %h", kbmatrix, exp_mat);
        end
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        send_raw(8'h29, ~^8'h29, 1'b0);  // stop bit low
        total++;
        if (fe_cnt - fe0 !== 1 || sv_cnt !== sv0 || kbmatrix !== exp_mat) begin
            bad++; $display("FAIL stop_err: got fe=%0d sv=%0d mat=%h want fe=1 sv=0 mat=%h",
                            fe_cnt - fe0, sv_cnt - sv0, kbmatrix, exp_mat);
        end
        send_byte(8'h5A);
        exp_mat[6] = 1'b0;
        total++;
        if (kbmatrix !== exp_mat || kbdcode !== 8'h5A) begin
            bad++; $display("FAIL enter_after_err: got %h/%h want %h/5a", kbmatrix, kbdcode, exp_mat);
        end
        send_byte(8'hF0);
        send_byte(8'h5A);
        exp_mat[6] = 1'b1;
        total++;
        if (kbmatrix !== exp_mat) begin
            bad++; $display("FAIL enter_break: got %h want %h", kbmatrix, exp_mat);
        end
    endtask

    task automatic test_timeout;
        int sv0, fe0, fall, lat;
        logic [7:0] d;
        d = 8'h1C;
        sv0 = sv_cnt;
        fe0 = fe_cnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        fall = last_fall;
        for (int i = 0; i < 400 && fe_cnt == fe0; i++) wait_cycles(1);
        wait_cycles(20);
        total++;
        if (fe_cnt - fe0 !== 1) begin
            bad++; $display("FAIL timeout_pulse: got %0d cycles want 1", fe_cnt - fe0);
        end
        lat = fe_cyc - fall;
        total++;
        if (lat < int'(TIMEOUT) || lat > int'(TIMEOUT + FILTER) + 6) begin
            bad++; $display("FAIL timeout_latency: got %0d want %0d..%0d", lat, TIMEOUT,
                            TIMEOUT + FILTER + 6);
        end
        total++;
        if (sv_cnt !== sv0 || kbmatrix !== exp_mat) begin
            bad++; $display("FAIL timeout_discard: got sv=%0d mat=%h want sv=0 mat=%h",
                            sv_cnt - sv0, kbmatrix, exp_mat);
        end
        send_byte(8'h1C);
        exp_mat[45] = 1'b0;
        total++;
        if (kbmatrix !== exp_mat || kbdcode !== 8'h1C) begin
            bad++; $display("FAIL after_timeout: got %h/%h want %h/1c", kbmatrix, kbdcode, exp_mat);
        end
        send_byte(8'hF0);
        send_byte(8'h1C);
        exp_mat[45] = 1'b1;
    endtask

    task automatic test_pause_bat;
        int sv0;
        logic [7:0] seq [8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        send_byte(8'h12);
        send_byte(8'h29);
        exp_mat[54] = 1'b0;
        exp_mat[46] = 1'b0;
        total++;
        if (kbmatrix !== exp_mat) begin
            bad++; $display("FAIL shift_space: got %h want %h", kbmatrix, exp_mat);
        end
        sv0 = sv_cnt;
        for (int i = 0; i < 8; i++) send_byte(seq[i]);
        total++;
        if (kbmatrix !== exp_mat) begin
            bad++; $display("FAIL pause_matrix: got %h want %h", kbmatrix, exp_mat);
        end
        total++;
        if (sv_cnt - sv0 !== 8 || kbdcode !== 8'h77) begin
            bad++; $display("FAIL pause_pulses: got sv=%0d code=%h want sv=8 code=77",
                            sv_cnt - sv0, kbdcode);
        end
        send_byte(8'hAA);
        exp_mat = '1;
        total++;
        if (kbmatrix !== exp_mat) begin
            bad++; $display("FAIL bat_matrix: got %h want %h", kbmatrix, exp_mat);
        end
    endtask

    task automatic test_reset_midframe;
        int fe0;
        logic [7:0] d;
        d = 8'h1C;
        send_byte(8'h66);
        exp_mat[7] = 1'b0;
        total++;
        if (kbmatrix !== exp_mat) begin
            bad++; $display("FAIL del_make: got %h want %h", kbmatrix, exp_mat);
        end
        send_byte(8'hF0);
        send_bit(1'b0);
        for (int i = 0; i < 5; i++) send_bit(d[i]);
        reset = 1'b1;
        wait_cycles(1);
        reset = 1'b0;
        fe0 = fe_cnt;
        wait_cycles(2);
        exp_mat = '1;
        total++;
        if (kbmatrix !== exp_mat || kbdcode !== 8'h00 || scan_valid !== 1'b0) begin
            bad++; $display("FAIL midframe_reset: got %h/%h/%b want %h/00/0",
                            kbmatrix, kbdcode, scan_valid, exp_mat);
        end
        ps2_data = 1'b1;
        wait_cycles(HP);
        send_byte(8'h59);   // F0 flag was lost, so this is a make
        exp_mat[63] = 1'b0;
        total++;
        if (kbmatrix !== exp_mat || kbdcode !== 8'h59) begin
            bad++; $display("FAIL after_reset_frame: got %h/%h want %h/59",
                            kbmatrix, kbdcode, exp_mat);
        end
        total++;
        if (fe_cnt !== fe0) begin
            bad++; $display("FAIL after_reset_err: got %0d err cycles want 0", fe_cnt - fe0);
        end
    endtask

    initial begin
        exp_mat = '1;
        test_reset();
        test_make_break();
        test_extended();
        test_frame_errors();
        test_timeout();
        test_pause_bat();
        test_reset_midframe();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
